stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control sequencer for the stopwatch digit counter. Conditions the pause and reset buttons
//  and generates the 1 Hz count-enable, the adjust-mode load strobes and the display blink.
//  Runs a RUN/PAUSE/ADJ state machine.
//  Sits between the board buttons/switches and the counter, which it drives with one-cycle strobes.
// PARAMETERS
//  TICK_DIV      100_000_000  clk_c cycles per count-enable (1 Hz at 100 MHz)
//  ADJ_DIV        50_000_000  clk_c cycles per adjust load strobe (2 Hz)
//  BLINK_DIV      25_000_000  clk_c cycles per blink_on toggle in ADJ
//  DEBOUNCE_CYC    1_000_000  cycles a synced button must be stable before its level is accepted
// PORTS
//  clk_c      in   1  system clock, single domain
//  reset_n_c  in   1  asynchronous, active-low reset
//  btn_pause  in   1  raw pause button, async, bouncy
//  btn_reset  in   1  raw clear button, async, bouncy
//  adj        in   1  adjust-mode switch (level, quasi-static)
//  sel        in   2  digit select: 00 sec units, 01 sec tens, 10 min units, 11 min tens
//  num        in   4  requested digit value
//  cnt_en     out  1  one-cycle advance strobe to the counter
//  cnt_clr    out  1  one-cycle clear strobe to the counter
//  ld_en      out  1  one-cycle digit load strobe
//  ld_sel     out  2  digit to load (valid with ld_en)
//  ld_val     out  4  clamped load value (valid with ld_en)
//  blink_on   out  1  display enable for the selected digit (blinks in ADJ)
//  paused     out  1  stored pause flag
// BEHAVIOUR
//  Reset (async assert, sync release): state=RUN, paused=0, all strobes=0, blink_on=1, all prescalers=0.
//  Button path: 2-FF sync -> debounce counter. The accepted level changes only after DEBOUNCE_CYC
//   consecutive equal samples. A one-cycle pulse fires on the accepted rising edge only.
//   Press-to-pulse latency: 2 + DEBOUNCE_CYC + 1 cycles.
//  FSM states: RUN, PAUSE, ADJ.
//   RUN   --pause_pulse--> PAUSE (paused<=1)
//   PAUSE --pause_pulse--> RUN   (paused<=0)
//   RUN/PAUSE --adj==1--> ADJ. The adj transition takes priority over pause_pulse in the same cycle.
//   ADJ   --adj==0--> PAUSE if paused, else RUN.
//   pause_pulse is ignored in ADJ.
//  Tick prescaler: counts only in RUN and holds its value in PAUSE/ADJ, so the partial second is kept.
//   cnt_en=1 for one cycle when the count reaches TICK_DIV-1, then the count wraps to 0.
//  reset_pulse (any state): cnt_clr=1 for one cycle and tick prescaler<=0, so the next cnt_en comes
//   TICK_DIV RUN cycles later. State and paused are unchanged.
//  Strobe priority in a single cycle: cnt_clr > ld_en > cnt_en. A suppressed strobe is dropped, not deferred.
//  ADJ load: the ADJ prescaler clears on ADJ entry. ld_en fires every ADJ_DIV cycles while in ADJ,
//   first strobe ADJ_DIV cycles after entry.
//   ld_sel/ld_val are registered from sel/num in the same cycle as ld_en.
//   Clamp rule: units digits (sel[0]=0) ld_val=min(num,9); tens digits (sel[0]=1) ld_val=min(num,5).
//  Blink: blink_on<=1 on ADJ entry, then toggles every BLINK_DIV cycles. It is forced to 1 outside ADJ.
//  All outputs are registered; no combinational path from any input to any output.
// STRUCTURE
//  stopwatch_pkg: state encoding (RUN=2'd0, PAUSE=2'd1, ADJ=2'd2), UNIT_MAX=4'd9, TENS_MAX=4'd5,
//   SEL_* digit codes.
//  Sub-module btn_conditioner (sync + debounce + rise pulse, param DEBOUNCE_CYC), instanced for
//   pause and for reset.
//  Prescaler widths are $clog2 of their divisors.
// TESTING (TICK_DIV=10, ADJ_DIV=6, BLINK_DIV=4, DEBOUNCE_CYC=3)
//  Release reset_n_c -> cnt_en at cycles 10, 20, 30; paused=0, blink_on=1, no ld_en/cnt_clr.
//  btn_pause glitch 2 cycles -> no change.
//   Hold 6 cycles -> paused=1 six cycles after press, cnt_en stops.
//   Second press -> resumes; first cnt_en arrives after the remaining prescale count.
//  adj=1, sel=01, num=7 -> ld_en every 6 cycles, ld_sel=01, ld_val=5; no cnt_en; blink_on toggles every 4.
//   Then sel=00, num=12 -> ld_val=9; sel=10, num=3 -> ld_val=3.
//  Reset pulse landing on a tick cycle -> cnt_clr=1 and cnt_en=0 that cycle; next cnt_en 10 cycles later.
//  Pause, adj=1, then adj=0 -> state returns to PAUSE, paused=1, blink_on=1, no cnt_en.
//  Assert reset_n_c mid-ADJ -> all strobes=0 and blink_on=1 immediately (async).
//   After release -> RUN, paused=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and helpers
// for the stopwatch control sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2
  } sw_state_e;

  localparam logic [3:0] UNIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  localparam logic [1:0] SEL_SEC_U = 2'b00;
  localparam logic [1:0] SEL_SEC_T = 2'b01;
  localparam logic [1:0] SEL_MIN_U = 2'b10;
  localparam logic [1:0] SEL_MIN_T = 2'b11;

  function automatic int unsigned cnt_w(
    input int unsigned div
  );
    return (div > 1) ? int'($clog2(div)) : 1;
  endfunction

  function automatic logic [3:0] clamp_digit(
    input logic [1:0] sel,
    input logic [3:0] num
  );
    logic [3:0] lim;
    lim = UNIT_MAX;
    unique case (sel)
      SEL_SEC_U, SEL_MIN_U: lim = UNIT_MAX;
      SEL_SEC_T, SEL_MIN_T: lim = TENS_MAX;
      default:              lim = UNIT_MAX;
    endcase
    return (num > lim) ? lim : num;
  endfunction

endpackage

// File: rtl/stopwatch_btn_conditioner.sv
// Button synchroniser, debouncer and
// one-cycle rising-edge pulse generator.
module btn_conditioner
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk_c,
  input  logic reset_n_c,
  input  logic i_btn,
  output logic o_rise
);

  localparam int unsigned DB_W = cnt_w(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_MAX =
    DB_W'(DEBOUNCE_CYC - 1);

  logic            r_s1;
  logic            r_s2;
  logic            r_level;
  logic            r_rise;
  logic [DB_W-1:0] r_db;

  always_ff @(posedge clk_c or negedge reset_n_c) begin
    if (!reset_n_c) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_db    <= '0;
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      // any sample matching the accepted level restarts the run
      if (r_s2 == r_level) begin
        r_db <= '0;
      end else if (r_db == DB_MAX) begin
        r_db    <= '0;
        r_level <= r_s2;
        r_rise  <= r_s2;
      end else begin
        r_db <= r_db + 1'b1;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: RUN/PAUSE/ADJ
// FSM, 1 Hz tick, adjust loads and blink.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned ADJ_DIV      = 50_000_000,
  parameter int unsigned BLINK_DIV    = 25_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk_c,
  input  logic       reset_n_c,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       adj,
  input  logic [1:0] sel,
  input  logic [3:0] num,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       ld_en,
  output logic [1:0] ld_sel,
  output logic [3:0] ld_val,
  output logic       blink_on,
  output logic       paused
);

  localparam int unsigned TK_W = cnt_w(TICK_DIV);
  localparam int unsigned AD_W = cnt_w(ADJ_DIV);
  localparam int unsigned BL_W = cnt_w(BLINK_DIV);

  localparam logic [TK_W-1:0] TK_MAX =
    TK_W'(TICK_DIV - 1);
  localparam logic [AD_W-1:0] AD_MAX =
    AD_W'(ADJ_DIV - 1);
  localparam logic [BL_W-1:0] BL_MAX =
    BL_W'(BLINK_DIV - 1);

  logic w_pause_pulse;
  logic w_reset_pulse;

  sw_state_e r_state;
  sw_state_e w_state_nxt;
  logic      r_paused;
  logic      w_paused_nxt;

  logic [TK_W-1:0] r_tick;
  logic [AD_W-1:0] r_adj_cnt;
  logic [BL_W-1:0] r_blk_cnt;

  logic       r_cnt_en;
  logic       r_cnt_clr;
  logic       r_ld_en;
  logic [1:0] r_ld_sel;
  logic [3:0] r_ld_val;
  logic       r_blink;

  logic w_adj_entry;
  logic w_tick_hit;
  logic w_ld_hit;
  logic w_blk_hit;

  btn_conditioner #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_pause (
    .clk_c     (clk_c),
    .reset_n_c (reset_n_c),
    .i_btn     (btn_pause),
    .o_rise    (w_pause_pulse)
  );

  btn_conditioner #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_reset (
    .clk_c     (clk_c),
    .reset_n_c (reset_n_c),
    .i_btn     (btn_reset),
    .o_rise    (w_reset_pulse)
  );

  always_ff @(posedge clk_c or negedge reset_n_c) begin
    if (!reset_n_c) begin
      r_state  <= ST_RUN;
      r_paused <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_paused <= w_paused_nxt;
    end
  end

  // adj wins over a pause pulse arriving in the same cycle
  always_comb begin
    w_state_nxt  = r_state;
    w_paused_nxt = r_paused;
    unique case (r_state)
      ST_RUN: begin
        if (adj) begin
          w_state_nxt = ST_ADJ;
        end else if (w_pause_pulse) begin
          w_state_nxt  = ST_PAUSE;
          w_paused_nxt = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (adj) begin
          w_state_nxt = ST_ADJ;
        end else if (w_pause_pulse) begin
          w_state_nxt  = ST_RUN;
          w_paused_nxt = 1'b0;
        end
      end
      ST_ADJ: begin
        if (!adj) begin
          w_state_nxt = r_paused ? ST_PAUSE : ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign w_adj_entry = (w_state_nxt == ST_ADJ) &&
                       (r_state != ST_ADJ);
  assign w_tick_hit  = (r_state == ST_RUN) &&
                       (r_tick == TK_MAX);
  assign w_ld_hit    = (r_state == ST_ADJ) &&
                       (r_adj_cnt == AD_MAX);
  assign w_blk_hit   = (r_state == ST_ADJ) &&
                       (r_blk_cnt == BL_MAX);

  // tick count survives PAUSE/ADJ so the partial second is kept
  always_ff @(posedge clk_c or negedge reset_n_c) begin
    if (!reset_n_c) begin
      r_tick <= '0;
    end else if (w_reset_pulse) begin
      r_tick <= '0;
    end else if (r_state == ST_RUN) begin
      r_tick <= w_tick_hit ? '0 : r_tick + 1'b1;
    end
  end

  always_ff @(posedge clk_c or negedge reset_n_c) begin
    if (!reset_n_c) begin
      r_adj_cnt <= '0;
      r_blk_cnt <= '0;
    end else if (w_adj_entry) begin
      r_adj_cnt <= '0;
      r_blk_cnt <= '0;
    end else if (r_state == ST_ADJ) begin
      r_adj_cnt <= w_ld_hit ? '0 : r_adj_cnt + 1'b1;
      r_blk_cnt <= w_blk_hit ? '0 : r_blk_cnt + 1'b1;
    end
  end

  // clear beats load beats tick; losers are dropped
  always_ff @(posedge clk_c or negedge reset_n_c) begin
    if (!reset_n_c) begin
      r_cnt_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_ld_en   <= 1'b0;
      r_ld_sel  <= '0;
      r_ld_val  <= '0;
    end else begin
      r_cnt_clr <= w_reset_pulse;
      r_ld_en   <= w_ld_hit && !w_reset_pulse;
      r_cnt_en  <= w_tick_hit && !w_reset_pulse &&
                   !w_ld_hit;
      if (w_ld_hit && !w_reset_pulse) begin
        r_ld_sel <= sel;
        r_ld_val <= clamp_digit(sel, num);
      end
    end
  end

  always_ff @(posedge clk_c or negedge reset_n_c) begin
    if (!reset_n_c) begin
      r_blink <= 1'b1;
    end else if (w_state_nxt != ST_ADJ) begin
      r_blink <= 1'b1;
    end else if (w_adj_entry) begin
      r_blink <= 1'b1;
    end else if (w_blk_hit) begin
      r_blink <= ~r_blink;
    end
  end

  assign cnt_en   = r_cnt_en;
  assign cnt_clr  = r_cnt_clr;
  assign ld_en    = r_ld_en;
  assign ld_sel   = r_ld_sel;
  assign ld_val   = r_ld_val;
  assign blink_on = r_blink;
  assign paused   = r_paused;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed table-driven bench for
// stopwatch_ctrl with short divisors.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       bp;
  logic       br;
  logic       adj;
  logic [1:0] sel;
  logic [3:0] num;
  logic       cnt_en;
  logic       cnt_clr;
  logic       ld_en;
  logic [1:0] ld_sel;
  logic [3:0] ld_val;
  logic       blink_on;
  logic       paused;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_ctrl #(
    .TICK_DIV     (10),
    .ADJ_DIV      (6),
    .BLINK_DIV    (4),
    .DEBOUNCE_CYC (3)
  ) dut (
    .clk_c     (clk),
    .reset_n_c (rst_n),
    .btn_pause (bp),
    .btn_reset (br),
    .adj       (adj),
    .sel       (sel),
    .num       (num),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .ld_en     (ld_en),
    .ld_sel    (ld_sel),
    .ld_val    (ld_val),
    .blink_on  (blink_on),
    .paused    (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       bp;
    logic       br;
    logic       adj;
    logic [1:0] sel;
    logic [3:0] num;
    int         e_cen;
    int         e_ld;
    int         e_clr;
    logic       f_cen;
    logic       f_ld;
    logic       f_clr;
    logic [1:0] f_sel;
    logic [3:0] f_val;
    logic       f_blink;
    logic       f_paused;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t V(
    input int n, input logic b_p,
    input logic b_r, input logic a,
    input logic [1:0] s, input logic [3:0] v,
    input int ec, input int el, input int ek,
    input logic fc, input logic fl,
    input logic fk, input logic [1:0] fs,
    input logic [3:0] fv, input logic fb,
    input logic fp
  );
    vec_t r;
    r.n = n; r.bp = b_p; r.br = b_r;
    r.adj = a; r.sel = s; r.num = v;
    r.e_cen = ec; r.e_ld = el; r.e_clr = ek;
    r.f_cen = fc; r.f_ld = fl; r.f_clr = fk;
    r.f_sel = fs; r.f_val = fv;
    r.f_blink = fb; r.f_paused = fp;
    return r;
  endfunction

  task automatic chk(
    input string name,
    input int act,
    input int exp
  );
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  task automatic run_seg(input int idx, input vec_t v);
    int c_cen;
    int c_ld;
    int c_clr;
    string p;
    c_cen = 0; c_ld = 0; c_clr = 0;
    p = $sformatf("seg%0d", idx);
    bp = v.bp; br = v.br; adj = v.adj;
    sel = v.sel; num = v.num;
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      if (cnt_en)  c_cen++;
      if (ld_en)   c_ld++;
      if (cnt_clr) c_clr++;
    end
    chk({p, ".cnt_en_count"},  c_cen, v.e_cen);
    chk({p, ".ld_en_count"},   c_ld,  v.e_ld);
    chk({p, ".cnt_clr_count"}, c_clr, v.e_clr);
    chk({p, ".cnt_en"},   int'(cnt_en),   int'(v.f_cen));
    chk({p, ".ld_en"},    int'(ld_en),    int'(v.f_ld));
    chk({p, ".cnt_clr"},  int'(cnt_clr),  int'(v.f_clr));
    chk({p, ".blink_on"}, int'(blink_on), int'(v.f_blink));
    chk({p, ".paused"},   int'(paused),   int'(v.f_paused));
    if (v.f_ld) begin
      chk({p, ".ld_sel"}, int'(ld_sel), int'(v.f_sel));
      chk({p, ".ld_val"}, int'(ld_val), int'(v.f_val));
    end
  endtask

  initial begin
    int c;
    // n bp br adj sel num | cnt ld clr | cen ld clr sel val blink paused
    tbl[0]  = V(10,0,0,0,0,0,  1,0,0, 1,0,0,0,0, 1,0);
    tbl[1]  = V(10,0,0,0,0,0,  1,0,0, 1,0,0,0,0, 1,0);
    tbl[2]  = V(10,0,0,0,0,0,  1,0,0, 1,0,0,0,0, 1,0);
    tbl[3]  = V(2, 1,0,0,0,0,  0,0,0, 0,0,0,0,0, 1,0);
    tbl[4]  = V(5, 0,0,0,0,0,  0,0,0, 0,0,0,0,0, 1,0);
    tbl[5]  = V(5, 1,0,0,0,0,  1,0,0, 0,0,0,0,0, 1,0);
    tbl[6]  = V(1, 1,0,0,0,0,  0,0,0, 0,0,0,0,0, 1,1);
    tbl[7]  = V(20,0,0,0,0,0,  0,0,0, 0,0,0,0,0, 1,1);
    tbl[8]  = V(6, 1,0,0,0,0,  0,0,0, 0,0,0,0,0, 1,0);
    tbl[9]  = V(6, 0,0,0,0,0,  0,0,0, 0,0,0,0,0, 1,0);
    tbl[10] = V(1, 0,0,0,0,0,  1,0,0, 1,0,0,0,0, 1,0);
    tbl[11] = V(4, 0,0,0,0,0,  0,0,0, 0,0,0,0,0, 1,0);
    tbl[12] = V(5, 0,1,0,0,0,  0,0,0, 0,0,0,0,0, 1,0);
    tbl[13] = V(1, 0,1,0,0,0,  0,0,1, 0,0,1,0,0, 1,0);
    tbl[14] = V(9, 0,0,0,0,0,  0,0,0, 0,0,0,0,0, 1,0);
    tbl[15] = V(1, 0,0,0,0,0,  1,0,0, 1,0,0,0,0, 1,0);
    tbl[16] = V(4, 0,0,1,1,7,  0,0,0, 0,0,0,0,0, 1,0);
    tbl[17] = V(2, 0,0,1,1,7,  0,0,0, 0,0,0,0,0, 0,0);
    tbl[18] = V(1, 0,0,1,1,7,  0,1,0, 0,1,0,1,5, 0,0);
    tbl[19] = V(6, 0,0,1,0,12, 0,1,0, 0,1,0,0,9, 0,0);
    tbl[20] = V(6, 0,0,1,2,3,  0,1,0, 0,1,0,2,3, 1,0);
    tbl[21] = V(6, 0,0,1,3,15, 0,1,0, 0,1,0,3,5, 1,0);
    tbl[22] = V(1, 0,0,0,3,15, 0,0,0, 0,0,0,0,0, 1,0);
    tbl[23] = V(8, 0,0,0,3,15, 0,0,0, 0,0,0,0,0, 1,0);
    tbl[24] = V(1, 0,0,0,3,15, 1,0,0, 1,0,0,0,0, 1,0);
    tbl[25] = V(6, 1,0,0,3,15, 0,0,0, 0,0,0,0,0, 1,1);
    tbl[26] = V(8, 0,0,1,3,15, 0,1,0, 0,0,0,0,0, 0,1);
    tbl[27] = V(1, 0,0,0,3,15, 0,0,0, 0,0,0,0,0, 1,1);
    tbl[28] = V(12,0,0,0,3,15, 0,0,0, 0,0,0,0,0, 1,1);
    tbl[29] = V(7, 0,0,1,3,15, 0,1,0, 0,1,0,3,5, 0,1);

    rst_n = 1'b0;
    bp = 1'b0; br = 1'b0; adj = 1'b0;
    sel = 2'd0; num = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst.cnt_en",   int'(cnt_en),   0);
    chk("rst.cnt_clr",  int'(cnt_clr),  0);
    chk("rst.ld_en",    int'(ld_en),    0);
    chk("rst.blink_on", int'(blink_on), 1);
    chk("rst.paused",   int'(paused),   0);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) run_seg(i, tbl[i]);

    // async reset while ADJ has ld_en high and blink low
    rst_n = 1'b0;
    #1;
    chk("async.ld_en",    int'(ld_en),    0);
    chk("async.cnt_en",   int'(cnt_en),   0);
    chk("async.cnt_clr",  int'(cnt_clr),  0);
    chk("async.blink_on", int'(blink_on), 1);
    chk("async.paused",   int'(paused),   0);
    adj = 1'b0; bp = 1'b0; br = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    repeat (9) begin
      @(negedge clk);
      if (cnt_en) c++;
    end
    chk("rel.early_cnt_en", c, 0);
    @(negedge clk);
    chk("rel.cnt_en_10", int'(cnt_en), 1);
    chk("rel.paused",    int'(paused), 0);

    // pause pulse and adj=1 arrive together: adj wins
    bp = 1'b1;
    repeat (5) @(negedge clk);
    adj = 1'b1;
    @(negedge clk);
    chk("prio.paused",   int'(paused),   0);
    chk("prio.blink_on", int'(blink_on), 1);
    adj = 1'b0; bp = 1'b0;
    @(negedge clk);
    chk("prio.exit_paused", int'(paused), 0);
    c = 0;
    repeat (3) begin
      @(negedge clk);
      if (cnt_en) c++;
    end
    chk("prio.early_cnt_en", c, 0);
    @(negedge clk);
    chk("prio.cnt_en_resume", int'(cnt_en), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
